// File: rtl/dense_layer.sv
// Fully-connected neural layer: buffers IN_COUNT fixed-point samples, then for
// each of OUT_COUNT neurons accumulates sample*weight products streamed from an
// external weight RAM, adds the neuron bias, rescales, saturates and optionally
// applies ReLU before handing the result out over a valid/ready handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// LOAD   | capturing IN_COUNT input samples into the buffer
// MAC    | streaming weights, accumulating buffer[i]*weight (IN_COUNT+1 cycles)
// BIAS   | adding bias, rescaling and registering the neuron result
// OUT    | presenting the result until the consumer accepts it
module dense_layer #(
    parameter int IN_COUNT  = 10,
    parameter int OUT_COUNT = 3,
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int RELU_EN   = 1
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               start,
    input  logic                                               dataInValid,
    input  logic [DATA_SIZE-1:0]                               dataIn,
    output logic [$clog2(IN_COUNT*OUT_COUNT)-1:0]              weightAdr,
    input  logic [DATA_SIZE-1:0]                               weightData,
    output logic [((OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1)-1:0] biasAdr,
    input  logic [DATA_SIZE-1:0]                               biasData,
    output logic                                               busy,
    output logic                                               outValid,
    input  logic                                               outReady,
    output logic [DATA_SIZE-1:0]                               dataOut,
    output logic [((OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1)-1:0] outIdx
);

    localparam int WA_W = $clog2(IN_COUNT * OUT_COUNT);
    localparam int OB_W = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
    localparam int IW   = $clog2(IN_COUNT);
    localparam int CW   = $clog2(IN_COUNT + 1);
    localparam int AW   = 2 * DATA_SIZE + $clog2(IN_COUNT);
    localparam int AW1  = AW + 1;

    localparam logic signed [AW1-1:0] SAT_MAX =
        {{(AW1 - DATA_SIZE + 1){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
    localparam logic signed [AW1-1:0] SAT_MIN =
        {{(AW1 - DATA_SIZE + 1){1'b1}}, {(DATA_SIZE - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_BIAS,
        S_OUT
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic signed [DATA_SIZE-1:0] buf_q [IN_COUNT];
    logic signed [DATA_SIZE-1:0] buf_d [IN_COUNT];
    logic signed [AW-1:0]        acc_q, acc_d;
    logic [WA_W-1:0]             weight_adr_q, weight_adr_d;
    logic [OB_W-1:0]             bias_adr_q, bias_adr_d;
    logic                        out_valid_q, out_valid_d;
    logic [DATA_SIZE-1:0]        data_out_q, data_out_d;
    logic [OB_W-1:0]             out_idx_q, out_idx_d;

    logic [IW-1:0]                 wr_idx;
    logic [IW-1:0]                 rd_idx;
    logic signed [2*DATA_SIZE-1:0] prod;
    logic signed [AW1-1:0]         bias_ext;
    logic signed [AW1-1:0]         sum;
    logic signed [AW1-1:0]         shifted;
    logic [DATA_SIZE-1:0]          result;

    assign weightAdr = weight_adr_q;
    assign biasAdr   = bias_adr_q;
    assign busy      = (state_q != S_IDLE);
    assign outValid  = out_valid_q;
    assign dataOut   = data_out_q;
    assign outIdx    = out_idx_q;

    // Datapath: product of the previous cycle's address (RAM latency of one) and the final rescale
    always_comb begin
        wr_idx   = IW'(cnt_q);
        rd_idx   = IW'(cnt_q - CW'(1));
        prod     = $signed(buf_q[rd_idx]) * $signed(weightData);
        bias_ext = AW1'($signed(biasData)) <<< FRAC_BITS;
        sum      = AW1'(acc_q) + bias_ext;
        shifted  = sum >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_SIZE-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_SIZE-1:0];
        end else begin
            result = shifted[DATA_SIZE-1:0];
        end
        if ((RELU_EN != 0) && result[DATA_SIZE-1]) begin
            result = '0;
        end
    end

    // Next-state and register updates for the sequencing FSM
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        acc_d        = acc_q;
        weight_adr_d = weight_adr_q;
        bias_adr_d   = bias_adr_q;
        out_valid_d  = out_valid_q;
        data_out_d   = data_out_q;
        out_idx_d    = out_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    cnt_d        = '0;
                    weight_adr_d = '0;
                    bias_adr_d   = '0;
                end
            end
            S_LOAD: begin
                if (dataInValid) begin
                    buf_d[wr_idx] = dataIn;
                    if (cnt_q == CW'(IN_COUNT - 1)) begin
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = S_MAC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_MAC: begin
                // cycle 0 only issues an address; data for it arrives next cycle
                if (cnt_q != '0) begin
                    acc_d = acc_q + AW'(prod);
                end
                if (cnt_q < CW'(IN_COUNT - 1)) begin
                    weight_adr_d = weight_adr_q + WA_W'(1);
                end
                if (cnt_q == CW'(IN_COUNT)) begin
                    cnt_d   = '0;
                    state_d = S_BIAS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BIAS: begin
                data_out_d  = result;
                out_idx_d   = bias_adr_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (outReady) begin
                    out_valid_d = 1'b0;
                    if (bias_adr_q == OB_W'(OUT_COUNT - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        // address sits on the last weight of this neuron, so +1 starts the next row
                        bias_adr_d   = bias_adr_q + OB_W'(1);
                        weight_adr_d = weight_adr_q + WA_W'(1);
                        acc_d        = '0;
                        cnt_d        = '0;
                        state_d      = S_MAC;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            weight_adr_q <= '0;
            bias_adr_q   <= '0;
            out_valid_q  <= 1'b0;
            data_out_q   <= '0;
            out_idx_q    <= '0;
            for (int i = 0; i < IN_COUNT; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            weight_adr_q <= weight_adr_d;
            bias_adr_q   <= bias_adr_d;
            out_valid_q  <= out_valid_d;
            data_out_q   <= data_out_d;
            out_idx_q    <= out_idx_d;
            buf_q        <= buf_d;
        end
    end

endmodule

// File: tb/tb_dense_layer.sv
// Bench for dense_layer: two instances (ReLU on and off) run in lockstep from
// shared stimulus, each with its own weight/bias RAM, checked against an
// integer reference of the layer arithmetic.
module tb_dense_layer;

    localparam int IN  = 4;
    localparam int OUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        din_v = 1'b0;
    logic [15:0] din = '0;
    logic        out_ready = 1'b0;

    logic [2:0]  wadr0, wadr1;
    logic [0:0]  badr0, badr1;
    logic [15:0] wdat0, wdat1, bdat0, bdat1;
    logic        busy0, busy1, ov0, ov1;
    logic [15:0] dout0, dout1;
    logic [0:0]  oidx0, oidx1;

    logic signed [15:0] x_v [IN];
    logic signed [15:0] w_v [IN*OUT];
    logic signed [15:0] b_v [OUT];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dense_layer #(.IN_COUNT(IN), .OUT_COUNT(OUT), .DATA_SIZE(16), .FRAC_BITS(8), .RELU_EN(1)) u_relu (
        .clk(clk), .rst(rst), .start(start), .dataInValid(din_v), .dataIn(din),
        .weightAdr(wadr0), .weightData(wdat0), .biasAdr(badr0), .biasData(bdat0),
        .busy(busy0), .outValid(ov0), .outReady(out_ready), .dataOut(dout0), .outIdx(oidx0)
    );

    dense_layer #(.IN_COUNT(IN), .OUT_COUNT(OUT), .DATA_SIZE(16), .FRAC_BITS(8), .RELU_EN(0)) u_lin (
        .clk(clk), .rst(rst), .start(start), .dataInValid(din_v), .dataIn(din),
        .weightAdr(wadr1), .weightData(wdat1), .biasAdr(badr1), .biasData(bdat1),
        .busy(busy1), .outValid(ov1), .outReady(out_ready), .dataOut(dout1), .outIdx(oidx1)
    );

    // one-cycle-latency RAMs, one set per instance
    always @(posedge clk) begin
        wdat0 <= w_v[wadr0];
        wdat1 <= w_v[wadr1];
        bdat0 <= b_v[badr0];
        bdat1 <= b_v[badr1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_out(input int j, input bit relu);
        longint s;
        s = 0;
        for (int i = 0; i < IN; i++) begin
            s += longint'(x_v[i]) * longint'(w_v[j*IN + i]);
        end
        s += longint'(b_v[j]) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic set_all(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                           input logic [15:0] x3, input logic [15:0] w, input logic [15:0] b);
        x_v[0] = x0; x_v[1] = x1; x_v[2] = x2; x_v[3] = x3;
        for (int i = 0; i < IN*OUT; i++) w_v[i] = w;
        for (int j = 0; j < OUT; j++) b_v[j] = b;
    endtask

    task automatic load_inputs(input int gap, input bit start_in_load);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < IN; i++) begin
            for (int g = 0; g < gap; g++) begin
                din_v = 1'b0; din = 16'hDEAD;
                @(negedge clk);
            end
            if (start_in_load && i == 2) begin
                start = 1'b1; din_v = 1'b0;
                @(negedge clk);
                start = 1'b0;
            end
            din_v = 1'b1; din = x_v[i];
            @(negedge clk);
        end
        din_v = 1'b0;
    endtask

    task automatic run_case(input string tag, input int gap, input int stall, input bit start_in_load);
        int k;
        logic [15:0] e0, e1;
        load_inputs(gap, start_in_load);
        for (int j = 0; j < OUT; j++) begin
            k = 0;
            while (!ov0 && k < 40) begin
                @(negedge clk);
                k++;
            end
            e0 = ref_out(j, 1'b1);
            e1 = ref_out(j, 1'b0);
            check($sformatf("%s_lat%0d", tag, j), k, 6);
            check($sformatf("%s_relu%0d", tag, j), dout0, e0);
            check($sformatf("%s_lin%0d", tag, j), dout1, e1);
            check($sformatf("%s_idx%0d", tag, j), oidx0, j);
            check($sformatf("%s_badr%0d", tag, j), badr0, j);
            check($sformatf("%s_ovl%0d", tag, j), ov1, 1);
            if (j == 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    check($sformatf("%s_hold_d%0d", tag, s), dout0, e0);
                    check($sformatf("%s_hold_v%0d", tag, s), ov0, 1);
                    check($sformatf("%s_hold_i%0d", tag, s), oidx0, 0);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check({tag, "_busy_end"}, {busy0, busy1}, 2'b00);
        check({tag, "_ov_end"}, {ov0, ov1}, 2'b00);
    endtask

    task automatic reset_in_mac();
        int seen;
        load_inputs(0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmac_busy", {busy0, busy1}, 2'b00);
        check("rstmac_ov", {ov0, ov1}, 2'b00);
        check("rstmac_dout", {dout0, dout1}, 32'h0);
        check("rstmac_idx", {oidx0, oidx1}, 2'b00);
        check("rstmac_adr", {wadr0, badr0}, 4'h0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ov0 || ov1 || busy0) seen++;
        end
        check("rstmac_quiet", seen, 0);
    endtask

    initial begin
        set_all(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {busy0, busy1}, 2'b00);
        check("rst_ov", {ov0, ov1}, 2'b00);
        check("rst_dout", {dout0, dout1}, 32'h0);
        check("rst_adr", {wadr0, badr0, oidx0}, 5'h0);
        rst = 1'b0;
        @(negedge clk);

        set_all(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0100, 16'h0080);
        run_case("nominal", 0, 0, 1'b0);

        set_all(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'hFF00, 16'h0080);
        run_case("negative", 0, 0, 1'b0);

        set_all(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_case("sat_pos", 0, 0, 1'b0);

        set_all(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000);
        run_case("sat_neg", 0, 0, 1'b0);

        set_all(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0100, 16'h0080);
        run_case("stall", 3, 5, 1'b1);

        reset_in_mac();
        run_case("post_rst", 0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < IN; i++) begin
                x_v[i] = (r < 6) ? 16'($urandom_range(0, 2047)) - 16'd1024 : 16'($urandom);
            end
            for (int i = 0; i < IN*OUT; i++) begin
                w_v[i] = (r < 6) ? 16'($urandom_range(0, 1023)) - 16'd512 : 16'($urandom);
            end
            for (int j = 0; j < OUT; j++) begin
                b_v[j] = (r < 6) ? 16'($urandom_range(0, 4095)) - 16'd2048 : 16'($urandom);
            end
            run_case($sformatf("rand%0d", r), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dense_layer.md
DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 Parameter IN_COUNT, default 10: inputs per inference (>=2).
REQ-002 Parameter OUT_COUNT, default 3: neurons, i.e. outputs per inference (>=1).
REQ-003 Parameter DATA_SIZE, default 16: signed two's-complement width of data, weights, biases and outputs.
REQ-004 Parameter FRAC_BITS, default 8: fractional bits of the fixed-point format.
REQ-005 Parameter RELU_EN, default 1: 1 applies ReLU to outputs; 0 passes them through.
REQ-006 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: begins an inference when sampled high in IDLE.
REQ-009 Port dataInValid, input, 1: dataIn holds a valid sample this cycle.
REQ-010 Port dataIn, input, DATA_SIZE: input sample.
REQ-011 Port weightAdr, output, $clog2(IN_COUNT*OUT_COUNT): weight RAM address.
REQ-012 Port weightData, input, DATA_SIZE: weight RAM data, one-cycle read latency.
REQ-013 Port biasAdr, output, $clog2(OUT_COUNT) (min 1): bias RAM address.
REQ-014 Port biasData, input, DATA_SIZE: bias RAM data, one-cycle read latency.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port outValid, output, 1: dataOut and outIdx are valid.
REQ-017 Port outReady, input, 1: consumer accepts the output.
REQ-018 Port dataOut, output, DATA_SIZE: neuron result.
REQ-019 Port outIdx, output, $clog2(OUT_COUNT) (min 1): index of the neuron in dataOut.

Function
REQ-020 The block SHALL implement the FSM IDLE -> LOAD on start, LOAD -> MAC after IN_COUNT accepted samples, MAC -> BIAS after the last product, BIAS -> OUT, OUT -> MAC (next neuron) or OUT -> IDLE (last neuron), with each OUT exit taken on outValid&&outReady.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 In LOAD, each cycle with dataInValid high SHALL store dataIn into an internal buffer at entry 0..IN_COUNT-1 in order; cycles with dataInValid low SHALL stall without error.
REQ-023 For neuron j and input i, weightAdr SHALL be j*IN_COUNT+i; biasAdr SHALL equal j throughout MAC, BIAS and OUT.
REQ-024 MAC SHALL issue one weight address per cycle and accumulate buffer[i]*weightData aligned to the one-cycle RAM latency.
REQ-025 The accumulator SHALL be signed, 2*DATA_SIZE+$clog2(IN_COUNT) bits wide, and cleared at the start of each neuron.
REQ-026 BIAS SHALL add biasData sign-extended and shifted left by FRAC_BITS.
REQ-027 The result SHALL be arithmetic-shifted right by FRAC_BITS (truncation toward -inf), then saturated to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1], then clamped to 0 if negative when RELU_EN=1.
REQ-028 MAC plus BIAS SHALL take exactly IN_COUNT+2 cycles per neuron; outValid SHALL rise in the cycle following BIAS.
REQ-029 While outValid is high and outReady is low, dataOut, outIdx and outValid SHALL hold stable.
REQ-030 The input buffer SHALL be retained across all OUT_COUNT neurons and not be reloaded.
REQ-031 busy SHALL fall in the cycle after the last neuron's handshake.

Reset
REQ-032 On rst: state=IDLE; busy=0, outValid=0, dataOut=0, outIdx=0, weightAdr=0, biasAdr=0; accumulator and counters cleared.
REQ-033 Assertion of rst at any point, including mid-LOAD or mid-MAC, SHALL abort the inference with no further outValid until a new start.

Verification (IN_COUNT=4, OUT_COUNT=2, DATA_SIZE=16, FRAC_BITS=8)
REQ-034 Nominal: all weights 0x0100, biases 0x0080, inputs 0x0100, 0x0200, 0x0300, 0x0400 -> dataOut=0x0A80 at outIdx 0 then outIdx 1; outValid asserted 6 cycles after the start of MAC.
REQ-035 Negative result: weights 0xFF00, same inputs and biases; RELU_EN=1 -> 0x0000; RELU_EN=0 -> 0xF680.
REQ-036 Saturation: inputs and weights all 0x7FFF, bias 0x7FFF -> 0x7FFF; inputs 0x8000 with weights 0x7FFF and RELU_EN=0 -> 0x8000.
REQ-037 Backpressure and stalls: dataInValid gaps of 3 cycles in LOAD and outReady low for 5 cycles on neuron 0 -> results identical to REQ-034 with outputs held stable during the stall.
REQ-038 Reset and ignored start: rst pulsed in MAC of neuron 0 -> outputs zero, busy=0, no outValid; start pulsed in LOAD is ignored; a subsequent full run matches REQ-034.
